ef_util_clk_gate_ctrl: RTL and testbench

Controller that drives the clk_en input of a peripheral clock-gating cell. It turns the gated clock on when a requester or software asks for it. It waits a fixed wake-up interval before granting access, and turns the clock off after a programmable number of idle cycles. It sits between bus/peripheral activity signals and the gating cell, and runs on the ungated clock.

---
 rtl/ef_util_clk_gate_ctrl.sv | 136 +++++++++++++
 tb/tb_ef_util_clk_gate_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ef_util_clk_gate_ctrl.sv
// Clock-gate enable controller: wakes the gated clock on activity, waits a fixed
// wake-up interval before granting ready, and gates off after a programmable idle time.
module ef_util_clk_gate_ctrl #(
  parameter int TIMEOUT_W   = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 auto_en,
  input  logic                 sw_force_on,
  input  logic                 req,
  input  logic                 busy,
  input  logic [TIMEOUT_W-1:0] idle_timeout,
  output logic                 clk_en,
  output logic                 ready,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     off_count
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [3:0]           WAKE_LOAD = 4'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] TO_ZERO   = {TIMEOUT_W{1'b0}};
  localparam logic [TIMEOUT_W-1:0] TO_ONE    = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [3:0]             wake_cnt_q, wake_cnt_d;
  logic [TIMEOUT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                   clk_en_q, clk_en_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       off_count_q, off_count_d;
  logic                   act;

  // Dropping auto_en counts as activity so the clock is held on while gating is disabled.
  assign act = req | busy | sw_force_on | ~auto_en;

  // Next-state and counter update.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_OFF: begin
        if (act) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_LOAD;
        end else begin
          state_d    = ST_OFF;
        end
      end
      ST_WAKE: begin
        // Wake-up always runs to completion, regardless of activity.
        if (wake_cnt_q == 4'd0) begin
          state_d    = ST_ON;
        end else begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end
      end
      ST_ON: begin
        if (act) begin
          state_d    = ST_ON;
        end else if (idle_timeout != TO_ZERO) begin
          state_d    = ST_DRAIN;
          idle_cnt_d = idle_timeout;
        end else begin
          state_d    = ST_OFF;
        end
      end
      ST_DRAIN: begin
        if (act) begin
          state_d    = ST_ON;
        end else if (idle_cnt_q == TO_ONE) begin
          state_d    = ST_OFF;
        end else begin
          idle_cnt_d = idle_cnt_q - TO_ONE;
        end
      end
      default: begin
        state_d    = ST_OFF;
        wake_cnt_d = 4'd0;
        idle_cnt_d = TO_ZERO;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move together with state.
  always_comb begin
    clk_en_d    = 1'b0;
    ready_d     = 1'b0;
    off_count_d = off_count_q;
    case (state_d)
      ST_OFF:   begin clk_en_d = 1'b0; ready_d = 1'b0; end
      ST_WAKE:  begin clk_en_d = 1'b1; ready_d = 1'b0; end
      ST_ON:    begin clk_en_d = 1'b1; ready_d = 1'b1; end
      ST_DRAIN: begin clk_en_d = 1'b1; ready_d = 1'b1; end
      default:  begin clk_en_d = 1'b0; ready_d = 1'b0; end
    endcase
    if ((state_d == ST_OFF) && (state_q != ST_OFF) && (off_count_q != CNT_MAX)) begin
      off_count_d = off_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      off_count_d = off_count_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      wake_cnt_q  <= 4'd0;
      idle_cnt_q  <= TO_ZERO;
      clk_en_q    <= 1'b0;
      ready_q     <= 1'b0;
      off_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      clk_en_q    <= clk_en_d;
      ready_q     <= ready_d;
      off_count_q <= off_count_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign ready     = ready_q;
  assign state     = state_q;
  assign off_count = off_count_q;

endmodule

// File: tb/tb_ef_util_clk_gate_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic compared against
// a cycle-level behavioural model of the gating rules.
module tb_ef_util_clk_gate_ctrl;

  localparam int TW = 8;
  localparam int WC = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          auto_en;
  logic          sw_force_on;
  logic          req;
  logic          busy;
  logic [TW-1:0] idle_timeout;
  logic          clk_en;
  logic          ready;
  logic [1:0]    state;
  logic [CW-1:0] off_count;

  int n_vec = 0;
  int n_err = 0;

  // model: mode 0=OFF 1=WAKE 2=ON 3=DRAIN, m_rem = cycles left in WAKE/DRAIN
  int m_state;
  int m_rem;
  int m_cnt;

  ef_util_clk_gate_ctrl #(.TIMEOUT_W(TW), .WAKE_CYCLES(WC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .sw_force_on(sw_force_on),
    .req(req), .busy(busy), .idle_timeout(idle_timeout),
    .clk_en(clk_en), .ready(ready), .state(state), .off_count(off_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0;
    m_rem   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    bit act;
    int prev;
    act  = req | busy | sw_force_on | ~auto_en;
    prev = m_state;
    case (m_state)
      0: if (act) begin m_state = 1; m_rem = WC; end
      1: begin m_rem = m_rem - 1; if (m_rem == 0) m_state = 2; end
      2: if (!act) begin
           if (idle_timeout == 0) m_state = 0;
           else begin m_state = 3; m_rem = int'(idle_timeout); end
         end
      default: if (act) m_state = 2;
               else begin m_rem = m_rem - 1; if (m_rem == 0) m_state = 0; end
    endcase
    if (prev != 0 && m_state == 0 && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
  endtask

  task automatic check(input string tag);
    logic [1:0]    es;
    logic          een;
    logic          erdy;
    logic [CW-1:0] ec;
    es   = 2'(m_state);
    een  = (m_state != 0);
    erdy = (m_state >= 2);
    ec   = CW'(m_cnt);
    n_vec++;
    assert (state === es) else begin
      n_err++; $error("FAIL %s state got %0d exp %0d", tag, state, es);
    end
    n_vec++;
    assert (clk_en === een) else begin
      n_err++; $error("FAIL %s clk_en got %0b exp %0b", tag, clk_en, een);
    end
    n_vec++;
    assert (ready === erdy) else begin
      n_err++; $error("FAIL %s ready got %0b exp %0b", tag, ready, erdy);
    end
    n_vec++;
    assert (off_count === ec) else begin
      n_err++; $error("FAIL %s off_count got %0d exp %0d", tag, off_count, ec);
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_step(); else model_reset();
      #1;
      check(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; auto_en = 1'b0; sw_force_on = 1'b0; req = 1'b0; busy = 1'b0;
    idle_timeout = '0;
    model_reset();
    repeat (10) begin
      @(negedge clk);
      check("reset");
    end
    auto_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    run(3, "idle");

    // basic wake / drain / off with timeout 3
    idle_timeout = 8'd3;
    req = 1'b1; run(8, "wake_on");
    req = 1'b0; run(6, "drain_off");

    // busy pulse on the last drain cycle rescues the clock
    req = 1'b1; run(5, "rewake");
    req = 1'b0; run(3, "drain_last");
    busy = 1'b1; run(1, "busy_rescue");
    busy = 1'b0; run(6, "idle_again");

    // zero timeout, then a timeout change during drain
    idle_timeout = 8'd0;
    req = 1'b1; run(4, "to0_on");
    req = 1'b0; run(3, "to0_off");
    idle_timeout = 8'd3;
    req = 1'b1; run(4, "to3_on");
    req = 1'b0; run(2, "to3_drain");
    idle_timeout = 8'd100; run(4, "to_change");

    // auto_en low forces the clock on
    auto_en = 1'b0;
    run(5, "forced");
    for (int i = 0; i < 10; i++) begin
      req = 1'($urandom); busy = 1'($urandom);
      run(1, "forced_rand");
    end
    req = 1'b0; busy = 1'b0; idle_timeout = 8'd2; auto_en = 1'b1;
    run(5, "auto_back");

    // saturate the 4-bit gate-off counter
    idle_timeout = 8'd0;
    repeat (18) begin
      req = 1'b1; run(4, "sat_on");
      req = 1'b0; run(2, "sat_off");
    end
    n_vec++;
    assert (off_count === 4'hF) else begin
      n_err++; $error("FAIL saturate off_count got %0d exp 15", off_count);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      auto_en      = ($urandom_range(0, 15) != 0);
      sw_force_on  = ($urandom_range(0, 19) == 0);
      busy         = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) req = ~req;
      if ($urandom_range(0, 9) == 0) idle_timeout = 8'($urandom_range(0, 6));
      run(1, "rand");
    end

    // asynchronous reset in the middle of WAKE
    auto_en = 1'b1; sw_force_on = 1'b0; busy = 1'b0; req = 1'b0; idle_timeout = 8'd0;
    run(20, "settle");
    req = 1'b1; run(1, "pre_rst_wake");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("async_rst");
    req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run(3, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
